// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS execute slice: the ALU control type and the
// named ALU control encodings produced by the ALU decoder.
//   alucontrol[2]   : invert operand B and inject a carry-in of 1 (subtract)
//   alucontrol[1:0] : result select (AND, OR, SUM, sign bit of SUM)
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef logic [2:0] alucontrol_t;

    localparam alucontrol_t ALUCTL_AND  = 3'b000;
    localparam alucontrol_t ALUCTL_OR   = 3'b001;
    localparam alucontrol_t ALUCTL_ADD  = 3'b010;
    localparam alucontrol_t ALUCTL_SUB  = 3'b110;
    localparam alucontrol_t ALUCTL_SLT  = 3'b111;
    localparam alucontrol_t ALUCTL_ANDN = 3'b100;
    localparam alucontrol_t ALUCTL_ORN  = 3'b101;

endpackage

// File: rtl/mips_alu_core.sv
// -----------------------------------------------------------------------------
// mips_alu_core
// Combinational MIPS ALU with zero flag.
// Ports:
//   srca       in  WIDTH  operand A
//   srcb       in  WIDTH  operand B
//   alucontrol in  3      operation select (see mips_pkg)
//   result     out WIDTH  ALU result
//   zero       out 1      1 when result is all zeros
// -----------------------------------------------------------------------------
module mips_alu_core
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  alucontrol_t      alucontrol,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] sum;

    // alucontrol[2] turns the adder into a subtractor (A + ~B + 1) and also
    // gives the inverted-operand logic ops AND-NOT / OR-NOT for free.
    assign bb  = alucontrol[2] ? ~srcb : srcb;
    assign sum = srca + bb + {{(WIDTH-1){1'b0}}, alucontrol[2]};

    always_comb begin
        result = '0;
        unique case (alucontrol[1:0])
            2'b00: result = srca & bb;
            2'b01: result = srca | bb;
            2'b10: result = sum;
            // SLT: sign of the raw difference; overflow deliberately ignored.
            2'b11: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_exec_slice.sv
// -----------------------------------------------------------------------------
// mips_exec_slice
// Execute slice of the multicycle MIPS datapath: combinational ALU, the
// enable-gated program counter and the unconditional ALUOut register.
// Ports:
//   clk        in  1      rising-edge clock
//   reset      in  1      synchronous, active-low reset
//   pcen       in  1      PC write enable
//   pcnext     in  WIDTH  next PC value
//   srca       in  WIDTH  ALU operand A
//   srcb       in  WIDTH  ALU operand B
//   alucontrol in  3      ALU operation select
//   aluresult  out WIDTH  combinational ALU result
//   zero       out 1      1 when aluresult is 0
//   pc         out WIDTH  registered program counter
//   aluout     out WIDTH  aluresult delayed by one cycle
// -----------------------------------------------------------------------------
module mips_exec_slice
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcen,
    input  logic [WIDTH-1:0] pcnext,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  alucontrol_t      alucontrol,
    output logic [WIDTH-1:0] aluresult,
    output logic             zero,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] aluout
);

    mips_alu_core #(
        .WIDTH(WIDTH)
    ) u_alu (
        .srca      (srca),
        .srcb      (srcb),
        .alucontrol(alucontrol),
        .result    (aluresult),
        .zero      (zero)
    );

    // Program counter: reset beats the enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= PC_RESET;
        end else if (pcen) begin
            pc <= pcnext;
        end
    end

    // ALUOut: captures the ALU result every cycle; reset drops the in-flight value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            aluout <= '0;
        end else begin
            aluout <= aluresult;
        end
    end

endmodule

// File: tb/tb_mips_exec_slice.sv
// -----------------------------------------------------------------------------
// tb_mips_exec_slice
// Self-checking bench for mips_exec_slice: directed reset / PC-enable / ALU
// corner cases followed by a randomized pipeline run against a behavioural
// reference model, with an expected queue for the one-cycle ALUOut delay.
// -----------------------------------------------------------------------------
module tb_mips_exec_slice;
    import mips_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic         clk;
    logic         reset;
    logic         pcen;
    logic [W-1:0] pcnext;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    alucontrol_t  alucontrol;
    logic [W-1:0] aluresult;
    logic         zero;
    logic [W-1:0] pc;
    logic [W-1:0] aluout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mips_exec_slice #(
        .WIDTH   (W),
        .PC_RESET(32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pcen      (pcen),
        .pcnext    (pcnext),
        .srca      (srca),
        .srcb      (srcb),
        .alucontrol(alucontrol),
        .aluresult (aluresult),
        .zero      (zero),
        .pc        (pc),
        .aluout    (aluout)
    );

    // ---------------- scoreboard ----------------
    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_r;
    logic [W-1:0] pc_model;

    // Reference model: each named operation written directly as arithmetic.
    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [2:0]   op);
        logic [W-1:0] t;
        case (op)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return a + b;
            3'b110: return a - b;
            3'b111: begin t = a - b; return {{(W-1){1'b0}}, t[W-1]}; end
            3'b100: return a & ~b;
            3'b101: return a | ~b;
            default: begin t = a + b; return {{(W-1){1'b0}}, t[W-1]}; end
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_case(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] op, input logic [W-1:0] expv);
        srca       = a;
        srcb       = b;
        alucontrol = op;
        #1;
        check(tag, aluresult, expv);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, (expv == 0)});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b0;
        pcen       = 1'b1;
        pcnext     = 32'h0000_0040;
        srca       = 32'd5;
        srcb       = 32'd3;
        alucontrol = ALUCTL_ADD;

        // Reset held for two edges: registers cleared, ALU still live.
        tick();
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_aluout", aluout, 32'h0);
        check("rst_aluresult", aluresult, 32'd8);

        reset = 1'b1;
        tick();
        check("post_rst_pc", pc, 32'h40);
        check("post_rst_aluout", aluout, 32'd8);

        // PC enable hold / load.
        pcen   = 1'b0;
        pcnext = 32'h0000_0080;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pc_hold", pc, 32'h40);
        end
        pcen = 1'b1;
        tick();
        check("pc_load", pc, 32'h80);

        // Arithmetic corners.
        alu_case("add_wrap", 32'hFFFF_FFFF, 32'h1, ALUCTL_ADD, 32'h0);
        alu_case("sub_eq", 32'd7, 32'd7, ALUCTL_SUB, 32'h0);
        alu_case("sub_neg", 32'd3, 32'd5, ALUCTL_SUB, 32'hFFFF_FFFE);

        // SLT corners, including the accepted overflow result.
        alu_case("slt_neg", 32'hFFFF_FFFF, 32'h1, ALUCTL_SLT, 32'h1);
        alu_case("slt_eq", 32'd5, 32'd5, ALUCTL_SLT, 32'h0);
        alu_case("slt_ovf", 32'h7FFF_FFFF, 32'h8000_0000, ALUCTL_SLT, 32'h1);

        // Logic ops.
        alu_case("and",  32'hF0F0_F0F0, 32'h0FF0_0FF0, ALUCTL_AND,  32'h00F0_00F0);
        alu_case("or",   32'hF0F0_F0F0, 32'h0FF0_0FF0, ALUCTL_OR,   32'hFFF0_FFF0);
        alu_case("andn", 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALUCTL_ANDN, 32'hF000_F000);
        alu_case("orn",  32'hF0F0_F0F0, 32'h0FF0_0FF0, ALUCTL_ORN,  32'hF0FF_F0FF);
        alu_case("op011", 32'h7FFF_FFFF, 32'h1, 3'b011, 32'h1);

        // Randomized pipeline run, reset pulsed in the middle.
        tick();
        pc_model = pc;
        check("pc_sync", pc, 32'h80);
        for (int i = 0; i < 20; i++) begin
            srca       = $urandom;
            srcb       = (i % 4 == 3) ? srca : $urandom;
            alucontrol = (i % 4 == 3) ? ALUCTL_SUB : 3'($urandom_range(0, 7));
            pcen       = 1'($urandom_range(0, 1));
            pcnext     = $urandom;
            reset      = (i == 10) ? 1'b0 : 1'b1;
            #1;
            exp_r = alu_ref(srca, srcb, alucontrol);
            check("rnd_aluresult", aluresult, exp_r);
            check("rnd_zero", {31'b0, zero}, {31'b0, (exp_r == 0)});
            exp_q.push_back(reset ? exp_r : 32'h0);
            if (!reset) pc_model = 32'h0;
            else if (pcen) pc_model = pcnext;
            tick();
            check("rnd_aluout", aluout, exp_q.pop_front());
            check("rnd_pc", pc, pc_model);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
